// File: rtl/stack_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared definitions for the return-address stack.
//   - OP_POP / OP_PUSH : control-unit opcodes that raise the pop / push strobes
//   - DEF_DEPTH, DEF_AW: default stack depth and stored return-address width
//   - stackOp_e        : decoded per-cycle stack operation
// ---------------------------------------------------------------------------
package stack_ctrl_pkg;

  localparam logic [5:0] OP_POP  = 6'b101000;
  localparam logic [5:0] OP_PUSH = 6'b101001;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 10;

  // STK_REPLACE is a simultaneous push+pop: the top entry is overwritten.
  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP,
    STK_REPLACE
  } stackOp_e;

endpackage

// File: rtl/stack_mem.sv
// ---------------------------------------------------------------------------
// stack_mem
// DEPTH x AW register array backing the return-address stack.
// Contents are deliberately not reset; validity is tracked by the owner.
// Ports:
//   i_clk    : clock, write happens on the rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : asynchronous read address
//   o_rdata  : asynchronous read data
// ---------------------------------------------------------------------------
module stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 10
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [AW-1:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [AW-1:0]              o_rdata
);

  logic [AW-1:0] r_mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is combinational so a return can use the top entry in its own cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Return-address stack controller for the CPU call/return path. Owns the
// stack pointer, the sticky error flags and the top-of-stack mux; storage
// lives in stack_mem.
// Ports:
//   i_clk      : system clock
//   i_reset    : asynchronous active-high reset (empties the stack)
//   i_push     : store i_ret_addr this cycle
//   i_pop      : remove top entry this cycle
//   i_ret_addr : return address to store (PC+1)
//   i_clr_err  : synchronous clear of o_ovf / o_unf
//   o_top      : current top entry, combinational, 0 when empty
//   o_count    : number of valid entries
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
//   o_ovf      : sticky overflow flag
//   o_unf      : sticky underflow flag
// ---------------------------------------------------------------------------
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [AW-1:0]              i_ret_addr,
  input  logic                       i_clr_err,
  output logic [AW-1:0]              o_top,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_ovf,
  output logic                       o_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);

  // r_sp points to the next free slot and doubles as the entry count.
  logic [PW:0]    r_sp;
  logic           r_ovf;
  logic           r_unf;

  logic [PW:0]    w_spNext;
  logic [PW:0]    w_topIdx;
  logic           w_full;
  logic           w_empty;
  logic           w_we;
  logic [PW-1:0]  w_waddr;
  logic [AW-1:0]  w_rdata;
  logic           w_setOvf;
  logic           w_setUnf;
  stackOp_e       w_op;

  assign w_full   = (r_sp == FULL_CNT);
  assign w_empty  = (r_sp == '0);
  assign w_topIdx = r_sp - ONE;

  stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_ret_addr),
    .i_raddr (w_topIdx[PW-1:0]),
    .o_rdata (w_rdata)
  );

  // Decode the strobes, then apply the full/empty guards before any pointer
  // move. An empty push+pop degrades to a push that also flags underflow.
  always_comb begin
    w_op     = STK_IDLE;
    w_spNext = r_sp;
    w_we     = 1'b0;
    w_waddr  = '0;
    w_setOvf = 1'b0;
    w_setUnf = 1'b0;

    case ({i_push, i_pop})
      2'b10:   w_op = STK_PUSH;
      2'b01:   w_op = STK_POP;
      2'b11:   w_op = STK_REPLACE;
      default: w_op = STK_IDLE;
    endcase

    case (w_op)
      STK_PUSH: begin
        if (w_full) begin
          w_setOvf = 1'b1;
        end else begin
          w_we     = 1'b1;
          w_waddr  = r_sp[PW-1:0];
          w_spNext = r_sp + ONE;
        end
      end
      STK_POP: begin
        if (w_empty) begin
          w_setUnf = 1'b1;
        end else begin
          w_spNext = r_sp - ONE;
        end
      end
      STK_REPLACE: begin
        w_we = 1'b1;
        if (w_empty) begin
          w_setUnf = 1'b1;
          w_waddr  = '0;
          w_spNext = ONE;
        end else begin
          w_waddr  = w_topIdx[PW-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  // Pointer and sticky flags; a new error event outranks a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_sp  <= w_spNext;
      r_ovf <= w_setOvf | (r_ovf & ~i_clr_err);
      r_unf <= w_setUnf | (r_unf & ~i_clr_err);
    end
  end

  assign o_top   = w_empty ? '0 : w_rdata;
  assign o_count = r_sp;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
// Directed bench for stack_ctrl (DEPTH=8, AW=10) with hand-computed
// expected values for push/pop ordering, full/overflow, empty/underflow,
// replace-top, sticky flag clearing and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 10;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [AW-1:0] retAddr;
  logic          clrErr;
  logic [AW-1:0] top;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;

  int compareCount  = 0;
  int mismatchCount = 0;

  stack_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_push     (push),
    .i_pop      (pop),
    .i_ret_addr (retAddr),
    .i_clr_err  (clrErr),
    .o_top      (top),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_ovf      (ovf),
    .o_unf      (unf)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs and let combinational paths settle.
  task automatic applyStimulus(input logic p, input logic q,
                               input logic [AW-1:0] addr, input logic clr);
    push    = p;
    pop     = q;
    retAddr = addr;
    clrErr  = clr;
    #1;
  endtask

  // Advance past the next rising edge and return inputs to idle.
  task automatic clockCycle();
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    retAddr = '0;
    clrErr  = 1'b0;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    retAddr = '0;
    clrErr  = 1'b0;
    #12;
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full",  32'(full),  0);
    checkOutput("rst_top",   32'(top),   0);
    checkOutput("rst_ovf",   32'(ovf),   0);
    checkOutput("rst_unf",   32'(unf),   0);

    // 1. LIFO order, pop reads top in its own cycle
    applyStimulus(1, 0, 10'h010, 0); clockCycle();
    applyStimulus(1, 0, 10'h020, 0); clockCycle();
    applyStimulus(1, 0, 10'h030, 0); clockCycle();
    checkOutput("t1_count", 32'(count), 3);
    checkOutput("t1_top",   32'(top),   32'h030);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t1_pop0", 32'(top), 32'h030); clockCycle();
    applyStimulus(0, 1, 0, 0);
    checkOutput("t1_pop1", 32'(top), 32'h020); clockCycle();
    applyStimulus(0, 1, 0, 0);
    checkOutput("t1_pop2", 32'(top), 32'h010); clockCycle();
    checkOutput("t1_empty", 32'(empty), 1);
    checkOutput("t1_topz",  32'(top),   0);
    checkOutput("t1_unf",   32'(unf),   0);

    // 2. Fill to DEPTH, overflow, clear, replace at full, drain
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, AW'(10'h100 + i), 0); clockCycle();
    end
    checkOutput("t2_full",  32'(full),  1);
    checkOutput("t2_count", 32'(count), 8);
    checkOutput("t2_top",   32'(top),   32'h107);
    applyStimulus(1, 0, 10'h3FF, 0); clockCycle();
    checkOutput("t2_ovf",    32'(ovf),   1);
    checkOutput("t2_count9", 32'(count), 8);
    checkOutput("t2_top9",   32'(top),   32'h107);
    applyStimulus(0, 0, 0, 1); clockCycle();
    checkOutput("t2_ovfclr", 32'(ovf), 0);
    applyStimulus(1, 1, 10'h2AA, 0);
    checkOutput("t2_repold", 32'(top), 32'h107); clockCycle();
    checkOutput("t2_repovf", 32'(ovf),   0);
    checkOutput("t2_repcnt", 32'(count), 8);
    checkOutput("t2_reptop", 32'(top),   32'h2AA);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t2_drain7", 32'(top), 32'h2AA); clockCycle();
    for (int i = DEPTH - 2; i >= 0; i--) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput($sformatf("t2_drain%0d", i), 32'(top), 32'h100 + 32'(i));
      clockCycle();
    end
    checkOutput("t2_empty", 32'(empty), 1);

    // 3. Underflow, clear, clear racing a new underflow
    applyStimulus(0, 1, 0, 0); clockCycle();
    checkOutput("t3_unf",   32'(unf),   1);
    checkOutput("t3_count", 32'(count), 0);
    checkOutput("t3_top",   32'(top),   0);
    applyStimulus(0, 0, 0, 1); clockCycle();
    checkOutput("t3_clr", 32'(unf), 0);
    applyStimulus(0, 1, 0, 1); clockCycle();
    checkOutput("t3_race", 32'(unf), 1);
    applyStimulus(0, 0, 0, 1); clockCycle();

    // 4. Replace top with two entries held
    applyStimulus(1, 0, 10'h011, 0); clockCycle();
    applyStimulus(1, 0, 10'h022, 0); clockCycle();
    applyStimulus(1, 1, 10'h055, 0);
    checkOutput("t4_old", 32'(top), 32'h022); clockCycle();
    checkOutput("t4_new",   32'(top),   32'h055);
    checkOutput("t4_count", 32'(count), 2);
    checkOutput("t4_unf",   32'(unf),   0);
    applyStimulus(0, 1, 0, 0); clockCycle();
    checkOutput("t4_below", 32'(top), 32'h011);
    applyStimulus(0, 1, 0, 0); clockCycle();

    // 5. Push+pop on empty acts as push and flags underflow
    applyStimulus(1, 1, 10'h0AA, 0); clockCycle();
    checkOutput("t5_count", 32'(count), 1);
    checkOutput("t5_top",   32'(top),   32'h0AA);
    checkOutput("t5_unf",   32'(unf),   1);
    applyStimulus(0, 1, 0, 1); clockCycle();

    // 6. Asynchronous reset with five entries, push in that cycle lost
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 0, AW'(i), 0); clockCycle();
    end
    checkOutput("t6_pre", 32'(count), 5);
    #1;
    reset   = 1'b1;
    push    = 1'b1;
    retAddr = 10'h3FF;
    #1;
    checkOutput("t6_count", 32'(count), 0);
    checkOutput("t6_empty", 32'(empty), 1);
    checkOutput("t6_top",   32'(top),   0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    push    = 1'b0;
    retAddr = '0;
    #1;
    checkOutput("t6_lost", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Hardware return-address stack controller for the single-cycle CPU's subroutine call/return path. It holds a register-file LIFO of program-counter values and manages the stack pointer. Push and pop strobes come from the control unit on the call and return opcodes. The top entry is presented combinationally so that a return completes in the same cycle as its pop strobe. Overflow and underflow are reported through sticky error flags.

Parameters:
DEPTH, 8, number of stack entries; must be a power of two, at least 2.
AW, 10, width of a stored return address (matches PC width).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
push  input  1  store ret_addr on the stack this cycle.
pop  input  1  remove the top entry this cycle.
ret_addr  input  AW  return address to store (PC+1, supplied by the datapath).
clr_err  input  1  synchronous clear of ovf and unf.
top  output  AW  current top entry, combinational; 0 when empty.
count  output  $clog2(DEPTH)+1  number of valid entries.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
ovf  output  1  sticky overflow flag.
unf  output  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, active-high): sp/count=0, ovf=0, unf=0. Entry storage is not reset. While empty, top=0, empty=1, full=0.
- sp points to the next free slot. top = mem[sp-1] when count>0, otherwise 0.
- Pop semantics: pop reads combinationally. The value on top during the pop cycle is the return target, and the datapath loads it into PC at the same edge. Latency is zero cycles for pop and one edge for push visibility.
- Push only, not full: mem[sp] <= ret_addr; sp <= sp+1.
- Push only, full: no write; sp unchanged; ovf <= 1.
- Pop only, not empty: sp <= sp-1.
- Pop only, empty: sp unchanged; unf <= 1; top reads 0.
- Push and pop together, not empty: replace the top entry, mem[sp-1] <= ret_addr; sp unchanged; no flags. The old top is visible during the cycle.
- Push and pop together, empty: treated as push only; unf <= 1; mem[0] <= ret_addr; sp <= 1.
- Push and pop together, full: replace top; no ovf.
- clr_err clears ovf and unf at the edge. An error event in the same cycle wins: the flag is set.
- Counters never wrap. The full and empty guards take priority over any increment or decrement.
- full, empty and count are derived combinationally from sp.
- Reset asserted mid-operation: the stack empties immediately. Any push in that cycle is lost.

Decomposition:
- Shared include cpu_defs.vh holds:
  - OP_POP = 6'b101000
  - OP_PUSH = 6'b101001
  - default stack DEPTH and AW constants
- Localparam PW = $clog2(DEPTH) is derived inside the module.
- One sub-module, stack_mem: DEPTH x AW register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port. stack_ctrl owns the pointer, flag logic and the top mux.

Test Plan:
1. Reset, then 3 pushes of 0x010, 0x020, 0x030. Expect count=3 and top=0x030. Then 3 pops: top reads 0x030, 0x020, 0x010 in the respective pop cycles. Finally empty=1 and top=0.
2. DEPTH=8: 8 pushes of 0x100+i. Expect full=1. A 9th push of 0x3FF sets ovf=1, count stays 8, and top stays 0x107.
3. Pop when empty: unf=1, count=0, top=0. Then clr_err for one cycle clears the flag to 0. clr_err coinciding with another empty pop leaves unf=1.
4. With 2 entries (0x011, 0x022), push+pop with ret_addr=0x055: top is 0x022 in that cycle. Next cycle top=0x055 and count=2.
5. Empty stack, push+pop with ret_addr=0x0AA: count=1, top=0x0AA, unf=1.
6. Assert reset asynchronously between edges with 5 entries held: count=0, empty=1 and top=0 immediately, before the next clk edge.
